// File: rtl/fpga_exunit_pkg.sv
// Shared types, widths and helpers for the FPGA execution unit.
package fpga_exunit_pkg;

  localparam int unsigned DATA_LEN        = 32;
  localparam int unsigned SRC_B_SEL_WIDTH = 2;
  localparam int unsigned FUNCT7_WIDTH    = 7;
  localparam int unsigned FUNCT3_WIDTH    = 3;
  localparam int unsigned RRF_SEL         = 6;
  localparam int unsigned SPECTAG_LEN     = 5;

  // Multiply occupies this many EXEC cycles; the counter holds cycles-1.
  localparam int unsigned MUL_CYCLES = 32;
  localparam int unsigned CNT_WIDTH  = 5;

  localparam logic [FUNCT3_WIDTH-1:0] OpMul  = 3'b000;
  localparam logic [FUNCT3_WIDTH-1:0] OpPopc = 3'b001;
  localparam logic [FUNCT3_WIDTH-1:0] OpClz  = 3'b010;
  localparam logic [FUNCT3_WIDTH-1:0] OpRotl = 3'b011;
  localparam logic [FUNCT3_WIDTH-1:0] OpRev8 = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } exu_state_e;

  function automatic logic [5:0] popcount32(input logic [DATA_LEN-1:0] a);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < DATA_LEN; i++) begin
      n = n + {5'b0, a[i]};
    end
    return n;
  endfunction

  // Zero input yields 32.
  function automatic logic [5:0] clz32(input logic [DATA_LEN-1:0] a);
    logic [5:0] n;
    logic       found;
    n     = 6'd32;
    found = 1'b0;
    for (int i = DATA_LEN - 1; i >= 0; i--) begin
      if (!found && a[i]) begin
        n     = 6'(DATA_LEN - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/exunit_fpga_if.sv
// Issue, branch-resolution and completion signals of the execution unit.
interface exunit_fpga_if;
  import fpga_exunit_pkg::*;

  logic                       issue;
  logic [DATA_LEN-1:0]        ex_src1;
  logic [DATA_LEN-1:0]        ex_src2;
  logic [DATA_LEN-1:0]        imm;
  logic [SRC_B_SEL_WIDTH-1:0] src_b;
  logic [FUNCT7_WIDTH-1:0]    funct7;
  logic [FUNCT3_WIDTH-1:0]    funct3;
  logic [RRF_SEL-1:0]         rrftag;
  logic                       dstval;
  logic [SPECTAG_LEN-1:0]     spectag;
  logic                       specbit;
  logic                       prmiss;
  logic                       prsuccess;
  logic [SPECTAG_LEN-1:0]     prtag;
  logic [SPECTAG_LEN-1:0]     specfixtag;

  logic                       busy;
  logic [DATA_LEN-1:0]        exrslt;
  logic [RRF_SEL-1:0]         exdst;
  logic                       exdstval;
  logic                       rslt_valid;
  logic                       kill_spec;

  modport master (
    output issue, ex_src1, ex_src2, imm, src_b, funct7, funct3, rrftag, dstval,
    output spectag, specbit, prmiss, prsuccess, prtag, specfixtag,
    input  busy, exrslt, exdst, exdstval, rslt_valid, kill_spec
  );

  modport slave (
    input  issue, ex_src1, ex_src2, imm, src_b, funct7, funct3, rrftag, dstval,
    input  spectag, specbit, prmiss, prsuccess, prtag, specfixtag,
    output busy, exrslt, exdst, exdstval, rslt_valid, kill_spec
  );

endinterface

// File: rtl/fpga_iter_mul.sv
// Radix-2 shift-add multiplier, low DATA_LEN bits of the product.
// The first partial product is folded into the start cycle so the result is
// ready in the last of MUL_CYCLES execute cycles.
module fpga_iter_mul
  import fpga_exunit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  output logic [DATA_LEN-1:0] product,
  output logic                done
);

  logic [DATA_LEN-1:0]  acc_q, acc_d;
  logic [DATA_LEN-1:0]  mcand_q, mcand_d;
  logic [DATA_LEN-1:0]  mplier_q, mplier_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 run_q, run_d;

  // One multiplier bit per cycle; start loads and consumes bit 0.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    run_d    = run_q;
    if (start) begin
      acc_d    = b[0] ? a : '0;
      mcand_d  = a << 1;
      mplier_d = b >> 1;
      rem_d    = CNT_WIDTH'(MUL_CYCLES - 1);
      run_d    = 1'b1;
    end else if (run_q && (rem_q != '0)) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      rem_d    = rem_q - CNT_WIDTH'(1);
    end
  end

  // Datapath state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      run_q    <= run_d;
    end
  end

  assign product = acc_q;
  assign done    = run_q && (rem_q == '0);

endmodule

// File: rtl/exunit_fpga.sv
// Multi-cycle execution unit: iterative MUL plus single-cycle bit ops, with
// speculative-kill handling driven by branch resolution.
module exunit_fpga
  import fpga_exunit_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  exunit_fpga_if.slave bus
);

  exu_state_e state_q, state_d;

  logic [DATA_LEN-1:0]     a_q, a_d;
  logic [4:0]              shamt_q, shamt_d;
  logic [FUNCT7_WIDTH-1:0] funct7_q, funct7_d;
  logic [FUNCT3_WIDTH-1:0] funct3_q, funct3_d;
  logic [RRF_SEL-1:0]      rrftag_q, rrftag_d;
  logic                    dstval_q, dstval_d;
  logic [SPECTAG_LEN-1:0]  spectag_q, spectag_d;
  logic                    specbit_q, specbit_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_LEN-1:0]     exrslt_q, exrslt_d;

  logic                busy;
  logic                kill;
  logic                in_kill;
  logic                accept;
  logic                spec_clear;
  logic                in_clear;
  logic                in_is_mul;
  logic                is_mul;
  logic [DATA_LEN-1:0] op_b;
  logic [DATA_LEN-1:0] alu_rslt;
  logic [DATA_LEN-1:0] mul_product;
  logic                mul_done;
  logic [2*DATA_LEN-1:0] rot_wide;
  logic                unused_src_b;

  assign unused_src_b = ^bus.src_b[SRC_B_SEL_WIDTH-1:1];

  assign op_b       = bus.src_b[0] ? bus.imm : bus.ex_src2;
  assign busy       = (state_q != StIdle);
  assign kill       = bus.prmiss & specbit_q & (|(spectag_q & bus.specfixtag));
  // An issue whose own tag is being squashed this cycle never enters the unit.
  assign in_kill    = bus.prmiss & bus.specbit & (|(bus.spectag & bus.specfixtag));
  assign accept     = bus.issue & ~busy & ~in_kill;
  assign spec_clear = bus.prsuccess & (bus.prtag == spectag_q);
  assign in_clear   = bus.prsuccess & (bus.prtag == bus.spectag);
  assign in_is_mul  = (bus.funct7 == '0) && (bus.funct3 == OpMul);
  assign is_mul     = (funct7_q == '0) && (funct3_q == OpMul);

  fpga_iter_mul u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept & in_is_mul),
    .a       (bus.ex_src1),
    .b       (op_b),
    .product (mul_product),
    .done    (mul_done)
  );

  // Rotate via doubled operand: the upper half is the left rotation.
  assign rot_wide = {a_q, a_q} << shamt_q;

  // Result select for the latched operation; undefined codes give zero.
  always_comb begin
    alu_rslt = '0;
    if (funct7_q == '0) begin
      case (funct3_q)
        OpMul:   alu_rslt = mul_product;
        OpPopc:  alu_rslt = DATA_LEN'(popcount32(a_q));
        OpClz:   alu_rslt = DATA_LEN'(clz32(a_q));
        OpRotl:  alu_rslt = rot_wide[2*DATA_LEN-1:DATA_LEN];
        OpRev8:  alu_rslt = {a_q[7:0], a_q[15:8], a_q[23:16], a_q[31:24]};
        default: alu_rslt = '0;
      endcase
    end
  end

  // Next-state and latch control.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    shamt_d   = shamt_q;
    funct7_d  = funct7_q;
    funct3_d  = funct3_q;
    rrftag_d  = rrftag_q;
    dstval_d  = dstval_q;
    spectag_d = spectag_q;
    specbit_d = specbit_q;
    cnt_d     = cnt_q;
    exrslt_d  = exrslt_q;

    if (spec_clear) begin
      specbit_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StExec;
          a_d       = bus.ex_src1;
          shamt_d   = op_b[4:0];
          funct7_d  = bus.funct7;
          funct3_d  = bus.funct3;
          rrftag_d  = bus.rrftag;
          dstval_d  = bus.dstval;
          spectag_d = bus.spectag;
          specbit_d = bus.specbit & ~in_clear;
          cnt_d     = in_is_mul ? CNT_WIDTH'(MUL_CYCLES - 1) : '0;
        end
      end
      StExec: begin
        if (kill) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          if (!is_mul || mul_done) begin
            state_d  = StDone;
            exrslt_d = alu_rslt;
          end
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and latched-operand registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      shamt_q   <= '0;
      funct7_q  <= '0;
      funct3_q  <= '0;
      rrftag_q  <= '0;
      dstval_q  <= 1'b0;
      spectag_q <= '0;
      specbit_q <= 1'b0;
      cnt_q     <= '0;
      exrslt_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      shamt_q   <= shamt_d;
      funct7_q  <= funct7_d;
      funct3_q  <= funct3_d;
      rrftag_q  <= rrftag_d;
      dstval_q  <= dstval_d;
      spectag_q <= spectag_d;
      specbit_q <= specbit_d;
      cnt_q     <= cnt_d;
      exrslt_q  <= exrslt_d;
    end
  end

  assign bus.busy       = busy;
  assign bus.exrslt     = exrslt_q;
  assign bus.exdst      = rrftag_q;
  assign bus.exdstval   = dstval_q;
  assign bus.rslt_valid = (state_q == StDone) & ~kill;
  assign bus.kill_spec  = (state_q == StDone) & kill;

endmodule

// File: tb/tb_exunit_fpga.sv
// Directed and randomized bench for exunit_fpga against a behavioural model.
module tb_exunit_fpga;
  import fpga_exunit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exunit_fpga_if bus ();

  exunit_fpga dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.issue = 0; bus.ex_src1 = '0; bus.ex_src2 = '0; bus.imm = '0; bus.src_b = '0;
    bus.funct7 = '0; bus.funct3 = '0; bus.rrftag = '0; bus.dstval = 0;
    bus.spectag = '0; bus.specbit = 0; bus.prmiss = 0; bus.prsuccess = 0;
    bus.prtag = '0; bus.specfixtag = '0;
  endtask

  // Behavioural reference: plain arithmetic on the operation definitions.
  function automatic logic [31:0] ref_result(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] b);
    longint unsigned p, x;
    logic [31:0] r, t;
    int n, s;
    if (f7 != 0) return 32'd0;
    case (f3)
      3'd0: begin p = longint'(a) * longint'(b); r = p[31:0]; return r; end
      3'd1: begin n = 0; t = a; while (t != 0) begin t = t & (t - 1); n++; end return 32'(n); end
      3'd2: begin n = 0; t = a; while (n < 32 && !t[31]) begin t = t << 1; n++; end
                  return 32'(n); end
      3'd3: begin s = int'(b % 32); x = longint'(a);
                  p = ((x << s) | (x >> (32 - s))) & 64'hFFFF_FFFF; r = p[31:0]; return r; end
      3'd4: begin for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*(3-i) +: 8]; return r; end
      default: return 32'd0;
    endcase
  endfunction

  // Issue an op, optionally poke a second issue while busy, and check completion.
  task automatic run_op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] s2, input logic [31:0] im,
                        input logic [1:0] sb, input logic [5:0] rt, input logic dv,
                        input bit poke);
    logic [31:0] bsel, exp;
    int          exp_lat, lat;
    bit          busy_ok;
    bsel    = sb[0] ? im : s2;
    exp     = ref_result(f7, f3, a, bsel);
    exp_lat = (f7 == 0 && f3 == 0) ? 33 : 2;
    bus.funct7 = f7; bus.funct3 = f3; bus.ex_src1 = a; bus.ex_src2 = s2; bus.imm = im;
    bus.src_b = sb; bus.rrftag = rt; bus.dstval = dv; bus.specbit = 0; bus.issue = 1;
    tick();
    bus.issue = 0;
    if (poke) begin
      bus.issue = 1; bus.ex_src1 = ~a; bus.funct3 = f3 + 3'd1; bus.rrftag = ~rt;
      bus.dstval = ~dv;
    end
    lat = 1;
    busy_ok = 1;
    while (!bus.rslt_valid && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 0;
      tick();
      bus.issue = 0;
      lat++;
    end
    if (bus.busy !== 1'b1) busy_ok = 0;
    chk($sformatf("%s.latency", tag), 64'(lat), 64'(exp_lat));
    chk($sformatf("%s.exrslt", tag), 64'(bus.exrslt), 64'(exp));
    chk($sformatf("%s.exdst", tag), 64'(bus.exdst), 64'(rt));
    chk($sformatf("%s.exdstval", tag), 64'(bus.exdstval), 64'(dv));
    chk($sformatf("%s.busy_held", tag), 64'(busy_ok), 64'd1);
    tick();
    chk($sformatf("%s.idle_after", tag), 64'(bus.busy), 64'd0);
    chk($sformatf("%s.rslt_stable", tag), 64'(bus.exrslt), 64'(exp));
  endtask

  task automatic watch_quiet(input string tag, input int n);
    bit seen;
    seen = 0;
    repeat (n) begin
      tick();
      if (bus.rslt_valid !== 1'b0) seen = 1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  task automatic issue_spec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag);
    bus.funct7 = '0; bus.funct3 = f3; bus.ex_src1 = a; bus.ex_src2 = b; bus.src_b = 2'b00;
    bus.rrftag = 6'h2A; bus.dstval = 1; bus.spectag = tag; bus.specbit = 1; bus.issue = 1;
  endtask

  initial begin
    logic [31:0] ra, rb, ri;
    idle_inputs();
    reset = 0;
    #2;
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.rslt_valid", 64'(bus.rslt_valid), 64'd0);
    chk("reset.kill_spec", 64'(bus.kill_spec), 64'd0);
    chk("reset.exrslt", 64'(bus.exrslt), 64'd0);
    chk("reset.exdst", 64'(bus.exdst), 64'd0);
    chk("reset.exdstval", 64'(bus.exdstval), 64'd0);
    tick(); tick();
    reset = 1;
    tick();

    run_op("popc", 7'd0, 3'd1, 32'hF0F0_0001, 32'h0, 32'h0, 2'b00, 6'h15, 1'b1, 1'b0);
    chk("popc.value9", 64'(bus.exrslt), 64'd9);
    run_op("mul_imm", 7'd0, 3'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'd3, 2'b01, 6'h07, 1'b1,
           1'b0);
    chk("mul_imm.value", 64'(bus.exrslt), 64'hFFFF_FFFD);
    run_op("clz0", 7'd0, 3'd2, 32'h0, 32'h0, 32'h0, 2'b00, 6'h01, 1'b0, 1'b0);
    run_op("f7nz", 7'h01, 3'd0, 32'hDEAD_BEEF, 32'h55, 32'h0, 2'b00, 6'h3F, 1'b1, 1'b0);
    run_op("f3_101", 7'd0, 3'd5, 32'hDEAD_BEEF, 32'h55, 32'h0, 2'b00, 6'h11, 1'b1, 1'b0);
    run_op("rev8", 7'd0, 3'd4, 32'h0102_0304, 32'h0, 32'h0, 2'b00, 6'h22, 1'b1, 1'b0);
    run_op("mul_poke", 7'd0, 3'd0, 32'h0001_0003, 32'h0000_0101, 32'h0, 2'b00, 6'h0C, 1'b1,
           1'b1);
    run_op("rotl_poke", 7'd0, 3'd3, 32'h8000_0001, 32'h0, 32'd31, 2'b11, 6'h30, 1'b0, 1'b1);

    // Speculative MUL killed in EXEC at T+10.
    issue_spec(3'd0, 32'h1234_5678, 32'h9, 5'b00010);
    tick(); idle_inputs();
    repeat (9) tick();
    chk("specmul.busy_t10", 64'(bus.busy), 64'd1);
    bus.prmiss = 1; bus.specfixtag = 5'b00010;
    #1;
    chk("specmul.kill_spec_exec", 64'(bus.kill_spec), 64'd0);
    tick(); idle_inputs();
    chk("specmul.idle_t11", 64'(bus.busy), 64'd0);
    watch_quiet("specmul.no_pulse", 40);

    // prsuccess at T+1 clears speculation so prmiss at T+2 does not kill.
    issue_spec(3'd3, 32'h8000_0F01, 32'hABCD_EF07, 5'b00100);
    tick(); idle_inputs();
    bus.prsuccess = 1; bus.prtag = 5'b00100;
    tick(); idle_inputs();
    bus.prmiss = 1; bus.specfixtag = 5'b00100;
    #1;
    chk("specrot.rslt_valid", 64'(bus.rslt_valid), 64'd1);
    chk("specrot.kill_spec", 64'(bus.kill_spec), 64'd0);
    chk("specrot.exrslt", 64'(bus.exrslt), 64'(ref_result(7'd0, 3'd3, 32'h8000_0F01, 32'd7)));
    tick(); idle_inputs();
    chk("specrot.idle", 64'(bus.busy), 64'd0);

    // Kill in DONE: squashed completion.
    issue_spec(3'd1, 32'hFFFF_0000, 32'h0, 5'b01000);
    tick(); idle_inputs();
    tick();
    bus.prmiss = 1; bus.specfixtag = 5'b11000;
    #1;
    chk("donekill.rslt_valid", 64'(bus.rslt_valid), 64'd0);
    chk("donekill.kill_spec", 64'(bus.kill_spec), 64'd1);
    tick(); idle_inputs();
    chk("donekill.idle", 64'(bus.busy), 64'd0);

    // Non-overlapping mask in DONE leaves the result alone.
    issue_spec(3'd1, 32'hFFFF_0000, 32'h0, 5'b01000);
    tick(); idle_inputs();
    tick();
    bus.prmiss = 1; bus.specfixtag = 5'b10111;
    #1;
    chk("nomask.rslt_valid", 64'(bus.rslt_valid), 64'd1);
    chk("nomask.exrslt", 64'(bus.exrslt), 64'd16);
    tick(); idle_inputs();

    // Issue coincident with a prmiss that kills its own tag is dropped.
    issue_spec(3'd1, 32'h1, 32'h0, 5'b10000);
    bus.prmiss = 1; bus.specfixtag = 5'b10000;
    tick(); idle_inputs();
    chk("drop.busy", 64'(bus.busy), 64'd0);
    watch_quiet("drop.no_pulse", 5);

    // prsuccess with the incoming tag clears specbit on entry.
    issue_spec(3'd2, 32'h0000_0100, 32'h0, 5'b00001);
    bus.prsuccess = 1; bus.prtag = 5'b00001;
    tick(); idle_inputs();
    bus.prmiss = 1; bus.specfixtag = 5'b00001;
    tick(); idle_inputs();
    #1;
    chk("inclear.rslt_valid", 64'(bus.rslt_valid), 64'd1);
    chk("inclear.exrslt", 64'(bus.exrslt), 64'd23);
    tick();

    // Issue during MUL, then asynchronous reset at T+5.
    bus.funct7 = '0; bus.funct3 = 3'd0; bus.ex_src1 = 32'h77; bus.ex_src2 = 32'h3;
    bus.rrftag = 6'h2D; bus.dstval = 1; bus.issue = 1;
    tick(); idle_inputs();
    tick();
    bus.funct3 = 3'd1; bus.ex_src1 = 32'hFF; bus.rrftag = 6'h01; bus.issue = 1;
    tick(); idle_inputs();
    tick(); tick();
    reset = 0;
    #1;
    chk("rstmid.busy", 64'(bus.busy), 64'd0);
    chk("rstmid.rslt_valid", 64'(bus.rslt_valid), 64'd0);
    chk("rstmid.kill_spec", 64'(bus.kill_spec), 64'd0);
    chk("rstmid.exrslt", 64'(bus.exrslt), 64'd0);
    chk("rstmid.exdst", 64'(bus.exdst), 64'd0);
    chk("rstmid.exdstval", 64'(bus.exdstval), 64'd0);
    tick(); tick();
    reset = 1;
    watch_quiet("rstmid.no_pulse", 45);
    chk("rstmid.idle", 64'(bus.busy), 64'd0);

    // Randomized mix.
    for (int k = 0; k < 40; k++) begin
      ra = $urandom();
      rb = $urandom();
      ri = $urandom();
      run_op($sformatf("rnd%0d", k),
             ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0,
             3'($urandom_range(0, 7)), ra, rb, ri, 2'($urandom_range(0, 3)),
             6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
